// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, imem handshake and IF/ID register
module fetch_stage #(
  parameter int              N        = 32,
  parameter logic [N-1:0]    RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pcWrite,
  input  logic          write_IFID,
  input  logic          branchTaken,
  input  logic [N-1:0]  branchTarget,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic [N-1:0]  pc_IFID,
  output logic [31:0]   instr_IFID,
  output logic          valid_IFID,
  output logic [4:0]    readReg1_IFID,
  output logic [4:0]    readReg2_IFID
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t       state, stateNext;
  logic [N-1:0] pc, pcNext;
  logic [N-1:0] drainAddr, drainAddrNext;
  logic [31:0]  holdBuf, holdBufNext;
  logic [N-1:0] pcIfidNext;
  logic [31:0]  instrIfidNext;
  logic         validIfidNext;
  logic         fetchReq;
  logic [N-1:0] fetchAddr;

  logic         advance;
  logic [N-1:0] target;
  logic [N-1:0] pcPlus4;

  assign advance = pcWrite & write_IFID;
  assign target  = {branchTarget[N-1:2], 2'b00};
  assign pcPlus4 = pc + N'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drainAddr  <= '0;
      holdBuf    <= '0;
      pc_IFID    <= '0;
      instr_IFID <= NOP;
      valid_IFID <= 1'b0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      drainAddr  <= drainAddrNext;
      holdBuf    <= holdBufNext;
      pc_IFID    <= pcIfidNext;
      instr_IFID <= instrIfidNext;
      valid_IFID <= validIfidNext;
    end
  end

  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    drainAddrNext = drainAddr;
    holdBufNext   = holdBuf;
    pcIfidNext    = pc_IFID;
    instrIfidNext = instr_IFID;
    validIfidNext = valid_IFID;
    fetchReq      = 1'b0;
    fetchAddr     = pc;

    case (state)
      FETCH: begin
        fetchReq = 1'b1;
        if (branchTaken) begin
          pcNext        = target;
          instrIfidNext = NOP;
          validIfidNext = 1'b0;
          // An unanswered request must finish at its original address first.
          if (!imem_ready) begin
            drainAddrNext = pc;
            stateNext     = DRAIN;
          end
        end else if (imem_ready) begin
          if (advance) begin
            pcIfidNext    = pc;
            instrIfidNext = imem_rdata;
            validIfidNext = 1'b1;
            pcNext        = pcPlus4;
          end else begin
            holdBufNext = imem_rdata;
            stateNext   = HOLD;
          end
        end else if (advance) begin
          instrIfidNext = NOP;
          validIfidNext = 1'b0;
        end
      end

      HOLD: begin
        if (branchTaken) begin
          pcNext        = target;
          instrIfidNext = NOP;
          validIfidNext = 1'b0;
          stateNext     = FETCH;
        end else if (advance) begin
          pcIfidNext    = pc;
          instrIfidNext = holdBuf;
          validIfidNext = 1'b1;
          pcNext        = pcPlus4;
          stateNext     = FETCH;
        end
      end

      DRAIN: begin
        fetchReq      = 1'b1;
        fetchAddr     = drainAddr;
        instrIfidNext = NOP;
        validIfidNext = 1'b0;
        if (branchTaken) begin
          pcNext = target;
        end
        if (imem_ready) begin
          stateNext = FETCH;
        end
      end

      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // Request is forced low combinationally so it drops the moment reset asserts.
  assign imem_req      = fetchReq & rst_n;
  assign imem_addr     = {fetchAddr[N-1:2], 2'b00};
  assign readReg1_IFID = instr_IFID[19:15];
  assign readReg2_IFID = instr_IFID[24:20];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcWrite, write_IFID, branchTaken;
  logic [31:0] branchTarget;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_IFID;
  logic [31:0] instr_IFID;
  logic        valid_IFID;
  logic [4:0]  readReg1_IFID, readReg2_IFID;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_pc_IFID;
  logic [31:0] w_instr_IFID;
  logic        w_valid_IFID;
  logic [4:0]  w_readReg1_IFID, w_readReg2_IFID;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.N(32), .RESET_PC(32'h0), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pcWrite(pcWrite), .write_IFID(write_IFID),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc_IFID(pc_IFID), .instr_IFID(instr_IFID),
    .valid_IFID(valid_IFID), .readReg1_IFID(readReg1_IFID), .readReg2_IFID(readReg2_IFID)
  );

  fetch_stage #(.N(32), .RESET_PC(32'hFFFFFFFC), .NOP(NOP)) dutWrap (
    .clk(clk), .rst_n(rst_n), .pcWrite(pcWrite), .write_IFID(write_IFID),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc_IFID(w_pc_IFID), .instr_IFID(w_instr_IFID),
    .valid_IFID(w_valid_IFID), .readReg1_IFID(w_readReg1_IFID), .readReg2_IFID(w_readReg2_IFID)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [31:0] data, input logic adv,
                       input logic br, input logic [31:0] tgt);
    imem_ready   = rdy;
    imem_rdata   = data;
    pcWrite      = adv;
    write_IFID   = adv;
    branchTaken  = br;
    branchTarget = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    entry_t e;
    e.pc    = pc;
    e.instr = instr;
    sb.push_back(e);
  endtask

  task automatic checkOut(input string tag);
    entry_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(valid_IFID), 32'd1);
      chk({tag, "_pc"}, pc_IFID, e.pc);
      chk({tag, "_instr"}, instr_IFID, e.instr);
      chk({tag, "_rs1"}, 32'(readReg1_IFID), 32'(e.instr[19:15]));
      chk({tag, "_rs2"}, 32'(readReg2_IFID), 32'(e.instr[24:20]));
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] last;

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(valid_IFID), 32'd0);
    chk("rst_instr", instr_IFID, NOP);
    chk("rst_pc_ifid", pc_IFID, 32'h0);
    chk("rst_wrap_req", 32'(w_imem_req), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_wrap_addr", w_imem_addr, 32'hFFFFFFFC);

    // streaming fetch, one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      chk("stream_addr", imem_addr, 32'(i * 4));
      drive(1'b1, w, 1'b1, 1'b0, 32'h0);
      push(32'(i * 4), w);
      last = w;
      tick();
      checkOut("stream");
      if (i == 0) chk("wrap_addr", w_imem_addr, 32'h0);
    end

    // load-use stall while response for 0x10 arrives
    w = $urandom;
    chk("stall_addr", imem_addr, 32'h10);
    drive(1'b1, w, 1'b0, 1'b0, 32'h0);
    tick();
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_pc_ifid", pc_IFID, 32'h0C);
    chk("hold_instr", instr_IFID, last);
    drive(1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    tick();
    chk("hold2_req", 32'(imem_req), 32'd0);
    chk("hold2_pc_ifid", pc_IFID, 32'h0C);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    push(32'h10, w);
    tick();
    checkOut("unstall");
    chk("unstall_req", 32'(imem_req), 32'd1);
    chk("unstall_addr", imem_addr, 32'h14);

    // no response but advancing: bubble
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("bubble_valid", 32'(valid_IFID), 32'd0);
    chk("bubble_instr", instr_IFID, NOP);
    chk("bubble_addr", imem_addr, 32'h14);

    // flush in FETCH with data returning; low target bits ignored
    drive(1'b1, 32'hBADBAD00, 1'b1, 1'b1, 32'h103);
    tick();
    chk("flush_valid", 32'(valid_IFID), 32'd0);
    chk("flush_instr", instr_IFID, NOP);
    chk("flush_addr", imem_addr, 32'h100);
    w = $urandom;
    drive(1'b1, w, 1'b1, 1'b0, 32'h0);
    push(32'h100, w);
    tick();
    checkOut("target");

    // flush with request to 0x104 still pending -> drain
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    tick();
    chk("drain_addr", imem_addr, 32'h104);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_valid", 32'(valid_IFID), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("drain2_addr", imem_addr, 32'h104);
    chk("drain2_valid", 32'(valid_IFID), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
    tick();
    chk("drain_br_addr", imem_addr, 32'h104);
    chk("drain_br_valid", 32'(valid_IFID), 32'd0);
    drive(1'b1, 32'hBADBAD01, 1'b1, 1'b0, 32'h0);
    tick();
    chk("drained_addr", imem_addr, 32'h300);
    chk("drained_valid", 32'(valid_IFID), 32'd0);
    w = $urandom;
    drive(1'b1, w, 1'b1, 1'b0, 32'h0);
    push(32'h300, w);
    tick();
    checkOut("after_drain");

    // branch and stall in the same cycle: flush wins
    drive(1'b1, 32'hBADBAD02, 1'b0, 1'b1, 32'h400);
    tick();
    chk("brstall_valid", 32'(valid_IFID), 32'd0);
    chk("brstall_req", 32'(imem_req), 32'd1);
    chk("brstall_addr", imem_addr, 32'h400);

    // branch while in HOLD
    drive(1'b1, 32'hBADBAD03, 1'b0, 1'b0, 32'h0);
    tick();
    chk("hold3_req", 32'(imem_req), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h500);
    tick();
    chk("holdbr_req", 32'(imem_req), 32'd1);
    chk("holdbr_addr", imem_addr, 32'h500);
    chk("holdbr_valid", 32'(valid_IFID), 32'd0);

    // async reset mid-DRAIN
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h600);
    tick();
    chk("pre_rst_addr", imem_addr, 32'h500);
    chk("pre_rst_pc_ifid", pc_IFID, 32'h300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_pc_ifid", pc_IFID, 32'h0);
    chk("arst_instr", instr_IFID, NOP);
    chk("arst_valid", 32'(valid_IFID), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("arst_rel_addr", imem_addr, 32'h0);
    chk("arst_rel_req", 32'(imem_req), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
